score_bcd_display: RTL and testbench

//  Parametrised successor of the 4-digit score display. Holds a DIGITS-wide BCD

---
 rtl/score_bcd_display_if.sv | 25 ++
 rtl/score_bcd_display.sv | 211 +++++++++++++++++++++
 tb/tb_score_bcd_display.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_bcd_display_if.sv
// Game-control / display bundle for the BCD score display.
interface score_bcd_display_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  Add_pulse;
  logic [3:0]            Add_value;
  logic                  Clear;
  logic                  Show_high;
  logic                  Busy;
  logic                  Overflow;
  logic [4*DIGITS-1:0]   Points;
  logic [4*DIGITS-1:0]   High_score;
  logic [7:0]            Smg_duan;
  logic [DIGITS-1:0]     Smg_we;

  modport master (
    output Add_pulse, Add_value, Clear, Show_high,
    input  Busy, Overflow, Points, High_score, Smg_duan, Smg_we
  );

  modport slave (
    input  Add_pulse, Add_value, Clear, Show_high,
    output Busy, Overflow, Points, High_score, Smg_duan, Smg_we
  );
endinterface

// File: rtl/score_bcd_display.sv
// DIGITS-wide BCD score keeper with high score, sticky overflow and a
// multiplexed common-anode 7-segment driver with leading-zero blanking.
module score_bcd_display #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SCAN_CYCLES = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic                 Clk_50mhz,
  input  logic                 Rst,
  score_bcd_display_if.slave   bus
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(SCAN_CYCLES);
  localparam int unsigned IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            add_pulse_q;
  logic [W-1:0]    work_q, work_d;
  logic [3:0]      carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_valid_q, pend_valid_d;
  logic [3:0]      pend_val_q, pend_val_d;
  logic [W-1:0]    points_q, points_d;
  logic [W-1:0]    high_q, high_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   scan_q, scan_d;
  logic [IW-1:0]   dig_q, dig_d;
  logic [DIGITS-1:0] we_q, we_d;
  logic [7:0]      duan_q, duan_d;

  logic            add_edge;
  logic            val_ok;
  logic [3:0]      cur_digit;
  logic [4:0]      sum;
  logic [W-1:0]    new_pts;
  logic [W-1:0]    view;
  logic [DIGITS-1:0] blank;
  logic            zero_above;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  assign add_edge  = bus.Add_pulse & ~add_pulse_q;
  assign val_ok    = (bus.Add_value != 4'd0) && (bus.Add_value <= 4'd9);
  assign cur_digit = work_q[{idx_q, 2'b00} +: 4];

  // Add/commit FSM next-state: Clear wins, pending slot is served before new edges.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    pend_valid_d = pend_valid_q;
    pend_val_d   = pend_val_q;
    points_d     = points_q;
    high_d       = high_q;
    ovf_d        = ovf_q;
    sum          = '0;
    new_pts      = '0;
    if (bus.Clear) begin
      state_d      = S_IDLE;
      pend_valid_d = 1'b0;
      points_d     = '0;
      ovf_d        = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pend_valid_q) begin
            work_d       = points_q;
            carry_d      = pend_val_q;
            idx_d        = '0;
            state_d      = S_ADD;
            // The slot frees up this clock, so a coincident edge refills it.
            pend_valid_d = add_edge && val_ok;
            pend_val_d   = bus.Add_value;
          end else if (add_edge && val_ok) begin
            work_d  = points_q;
            carry_d = bus.Add_value;
            idx_d   = '0;
            state_d = S_ADD;
          end
        end
        S_ADD: begin
          sum = {1'b0, cur_digit} + {1'b0, carry_q};
          if (sum > 5'd9) begin
            work_d[{idx_q, 2'b00} +: 4] = 4'(sum - 5'd10);
            carry_d = 4'd1;
          end else begin
            work_d[{idx_q, 2'b00} +: 4] = sum[3:0];
            carry_d = 4'd0;
          end
          if (idx_q == IW'(DIGITS - 1)) begin
            state_d = S_CMP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          if (add_edge && val_ok && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_val_d   = bus.Add_value;
          end
        end
        S_CMP: begin
          if (carry_q != 4'd0) begin
            new_pts = {DIGITS{4'h9}};
            ovf_d   = 1'b1;
          end else begin
            new_pts = work_q;
          end
          points_d = new_pts;
          // Packed BCD with valid digits orders the same as plain binary.
          if (new_pts > high_q) high_d = new_pts;
          state_d = S_IDLE;
          if (add_edge && val_ok && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_val_d   = bus.Add_value;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Scan counter, digit index and registered segment/enable outputs.
  always_comb begin
    scan_d     = scan_q;
    dig_d      = dig_q;
    we_d       = we_q;
    duan_d     = duan_q;
    view       = bus.Show_high ? high_q : points_q;
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned j = 0; j < DIGITS - 1; j++) begin
      zero_above = zero_above & (view[4*(DIGITS-1-j) +: 4] == 4'd0);
      blank[DIGITS-1-j] = (BLANK_LZ != 0) && zero_above;
    end
    if (scan_q == CW'(SCAN_CYCLES - 1)) begin
      scan_d = '0;
      dig_d  = (dig_q == IW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
      we_d   = '1;
      we_d[dig_d] = 1'b0;
      duan_d = blank[dig_d] ? 8'hFF : seg7(view[{dig_d, 2'b00} +: 4]);
    end else begin
      scan_d = scan_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge Clk_50mhz or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      add_pulse_q  <= 1'b0;
      work_q       <= '0;
      carry_q      <= '0;
      idx_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      points_q     <= '0;
      high_q       <= '0;
      ovf_q        <= 1'b0;
      scan_q       <= '0;
      dig_q        <= '0;
      we_q         <= '1;
      duan_q       <= 8'hFF;
    end else begin
      state_q      <= state_d;
      add_pulse_q  <= bus.Add_pulse;
      work_q       <= work_d;
      carry_q      <= carry_d;
      idx_q        <= idx_d;
      pend_valid_q <= pend_valid_d;
      pend_val_q   <= pend_val_d;
      points_q     <= points_d;
      high_q       <= high_d;
      ovf_q        <= ovf_d;
      scan_q       <= scan_d;
      dig_q        <= dig_d;
      we_q         <= we_d;
      duan_q       <= duan_d;
    end
  end

  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.Overflow   = ovf_q;
  assign bus.Points     = points_q;
  assign bus.High_score = high_q;
  assign bus.Smg_duan   = duan_q;
  assign bus.Smg_we     = we_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display (DIGITS=4, SCAN_CYCLES=8).
module tb_score_bcd_display;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned SCAN   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_bcd_display_if #(.DIGITS(DIGITS)) bus ();

  score_bcd_display #(
    .DIGITS(DIGITS),
    .SCAN_CYCLES(SCAN),
    .BLANK_LZ(1)
  ) dut (
    .Clk_50mhz(clk),
    .Rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  val;
    logic [15:0] exp_points;
    int          exp_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_add(input logic [3:0] v);
    bus.Add_value = v;
    bus.Add_pulse = 1'b1;
    tick();
    bus.Add_pulse = 1'b0;
    repeat (DIGITS + 2) tick();
  endtask

  task automatic do_clear();
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
  endtask

  task automatic load(input int n);
    int r;
    r = n;
    do_clear();
    while (r >= 9) begin
      do_add(4'd9);
      r -= 9;
    end
    if (r > 0) do_add(4'(r));
  endtask

  // Waits for the next digit-slot update; returns clocks waited.
  task automatic wait_slot(output int cycles, output bit ok);
    logic [DIGITS-1:0] prev;
    prev   = bus.Smg_we;
    cycles = 0;
    ok     = 1'b0;
    while (!ok && cycles < 4 * SCAN) begin
      tick();
      cycles++;
      if (bus.Smg_we !== prev) ok = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL slot_timeout actual=%0d required=<%0d", cycles, 4 * SCAN);
    end
  endtask

  function automatic int we_index(input logic [DIGITS-1:0] we);
    int idx;
    idx = -1;
    for (int k = 0; k < int'(DIGITS); k++) if (we[k] == 1'b0) idx = k;
    return idx;
  endfunction

  function automatic int zero_count(input logic [DIGITS-1:0] we);
    int c;
    c = 0;
    for (int k = 0; k < int'(DIGITS); k++) if (we[k] == 1'b0) c++;
    return c;
  endfunction

  initial begin
    int cnt;
    int cyc;
    bit ok;
    int idx;
    int prev_idx;
    logic [7:0] exp_seg[4];

    vecs[0] = '{4'd5,  16'h0005, 5};
    vecs[1] = '{4'd9,  16'h0014, 5};
    vecs[2] = '{4'd0,  16'h0014, 0};
    vecs[3] = '{4'd12, 16'h0014, 0};
    vecs[4] = '{4'd6,  16'h0020, 5};
    vecs[5] = '{4'd9,  16'h0029, 5};
    vecs[6] = '{4'd1,  16'h0030, 5};
    vecs[7] = '{4'd15, 16'h0030, 0};

    bus.Add_pulse = 1'b0;
    bus.Add_value = 4'd0;
    bus.Clear     = 1'b0;
    bus.Show_high = 1'b0;
    rst = 1'b1;
    #12;
    check("rst_points", bus.Points, 16'h0000);
    check("rst_high",   bus.High_score, 16'h0000);
    check("rst_ovf",    bus.Overflow, 1'b0);
    check("rst_busy",   bus.Busy, 1'b0);
    check("rst_duan",   bus.Smg_duan, 8'hFF);
    check("rst_we",     bus.Smg_we, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table-driven adds, including dropped values 0, 12, 15.
    do_clear();
    for (int i = 0; i < 8; i++) begin
      cnt = 0;
      bus.Add_value = vecs[i].val;
      bus.Add_pulse = 1'b1;
      tick();
      bus.Add_pulse = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (bus.Busy) cnt++;
        tick();
      end
      check($sformatf("vec%0d_points", i), bus.Points, vecs[i].exp_points);
      check($sformatf("vec%0d_busy", i), cnt, vecs[i].exp_busy);
    end
    check("vec_high", bus.High_score, 16'h0030);

    // 0098 + 5 -> 0103, commit latency and Busy window.
    load(98);
    check("load98", bus.Points, 16'h0098);
    check("high98", bus.High_score, 16'h0098);
    bus.Add_value = 4'd5;
    bus.Add_pulse = 1'b1;
    tick();
    bus.Add_pulse = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      if (bus.Busy) cnt++;
      if (k < 5) check($sformatf("lat_hold%0d", k), bus.Points, 16'h0098);
      tick();
    end
    check("lat_commit", bus.Points, 16'h0103);
    check("lat_busy_cycles", cnt, 5);
    check("lat_busy_low", bus.Busy, 1'b0);
    check("high103", bus.High_score, 16'h0103);

    // Scan of 0103: digit3 blanked, digit1 zero shown.
    exp_seg[0] = 8'hB0;
    exp_seg[1] = 8'hC0;
    exp_seg[2] = 8'hF9;
    exp_seg[3] = 8'hFF;
    wait_slot(cyc, ok);
    prev_idx = we_index(bus.Smg_we);
    for (int s = 0; s < 5; s++) begin
      wait_slot(cyc, ok);
      idx = we_index(bus.Smg_we);
      check($sformatf("scan%0d_onehot", s), zero_count(bus.Smg_we), 1);
      check($sformatf("scan%0d_order", s), idx, (prev_idx + 1) % 4);
      check($sformatf("scan%0d_period", s), cyc, SCAN);
      if (idx >= 0) check($sformatf("scan%0d_seg", s), bus.Smg_duan, exp_seg[idx]);
      prev_idx = idx;
    end

    // Held level gives one event.
    do_clear();
    bus.Add_value = 4'd2;
    bus.Add_pulse = 1'b1;
    repeat (100) tick();
    bus.Add_pulse = 1'b0;
    tick();
    check("held_one_add", bus.Points, 16'h0002);

    // Edge while busy -> pending; third edge with slot full -> dropped.
    bus.Add_value = 4'd2; bus.Add_pulse = 1'b1; tick();
    bus.Add_pulse = 1'b0; tick();
    bus.Add_value = 4'd7; bus.Add_pulse = 1'b1; tick();
    bus.Add_pulse = 1'b0; tick();
    bus.Add_value = 4'd4; bus.Add_pulse = 1'b1; tick();
    bus.Add_pulse = 1'b0;
    repeat (20) tick();
    check("pending_sum", bus.Points, 16'h0011);
    check("pending_idle", bus.Busy, 1'b0);

    // Clear during ADD digit 1.
    do_clear();
    do_add(4'd8);
    bus.Add_value = 4'd5; bus.Add_pulse = 1'b1; tick();
    bus.Add_pulse = 1'b0; tick();
    bus.Clear = 1'b1; tick();
    bus.Clear = 1'b0;
    check("abort_points", bus.Points, 16'h0000);
    check("abort_busy", bus.Busy, 1'b0);
    repeat (8) tick();
    check("abort_no_commit", bus.Points, 16'h0000);

    // Edge in the same cycle as Clear is dropped.
    bus.Clear = 1'b1; bus.Add_value = 4'd3; bus.Add_pulse = 1'b1; tick();
    bus.Clear = 1'b0; bus.Add_pulse = 1'b0;
    repeat (8) tick();
    check("clear_edge_drop", bus.Points, 16'h0000);

    // Clear drops the pending slot.
    bus.Add_value = 4'd4; bus.Add_pulse = 1'b1; tick();
    bus.Add_pulse = 1'b0; tick();
    bus.Add_value = 4'd3; bus.Add_pulse = 1'b1; tick();
    bus.Add_pulse = 1'b0;
    bus.Clear = 1'b1; tick();
    bus.Clear = 1'b0;
    repeat (12) tick();
    check("clear_pend_drop", bus.Points, 16'h0000);

    // Saturation and sticky overflow.
    load(9995);
    check("load9995", bus.Points, 16'h9995);
    do_add(4'd7);
    check("ovf_points", bus.Points, 16'h9999);
    check("ovf_flag", bus.Overflow, 1'b1);
    check("ovf_high", bus.High_score, 16'h9999);
    do_add(4'd1);
    check("ovf_stay_points", bus.Points, 16'h9999);
    check("ovf_stay_flag", bus.Overflow, 1'b1);
    do_clear();
    check("clr_points", bus.Points, 16'h0000);
    check("clr_ovf", bus.Overflow, 1'b0);
    check("clr_high_kept", bus.High_score, 16'h9999);

    // View select: score 0000 shows only digit 0, high score shows 9s.
    wait_slot(cyc, ok);
    idx = we_index(bus.Smg_we);
    check("view_score_seg", bus.Smg_duan, (idx == 0) ? 8'hC0 : 8'hFF);
    bus.Show_high = 1'b1;
    wait_slot(cyc, ok);
    check("view_high_seg0", bus.Smg_duan, 8'h90);
    wait_slot(cyc, ok);
    check("view_high_seg1", bus.Smg_duan, 8'h90);
    check("view_high_period", cyc, SCAN);
    bus.Show_high = 1'b0;

    // Asynchronous reset mid-scan.
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_we", bus.Smg_we, 4'hF);
    check("mid_rst_duan", bus.Smg_duan, 8'hFF);
    check("mid_rst_high", bus.High_score, 16'h0000);
    check("mid_rst_busy", bus.Busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_we", bus.Smg_we, 4'hF);
    check("post_rst_points", bus.Points, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
